// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard.
//   slot_t      : one in-flight register write (valid, destination, latency)
//   SLOT_EMPTY  : value of an unoccupied slot
//   FWD_REGFILE : forwarding select meaning "read the register file"
//   LAT_ALU/LOAD: forwardable slot index for ALU results and loads
package hazard_pkg;

  // Slot fields are sized for the widest supported build; narrower
  // register addresses and latencies are zero-extended into them.
  localparam int SLOT_RD_W  = 32'd8;
  localparam int SLOT_LAT_W = 32'd8;

  localparam int FWD_REGFILE = 32'd0;
  localparam int LAT_ALU     = 32'd1;
  localparam int LAT_LOAD    = 32'd2;

  typedef struct packed {
    logic                  valid;
    logic [SLOT_RD_W-1:0]  rd;
    logic [SLOT_LAT_W-1:0] lat;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0,
                                   rd:    {SLOT_RD_W{1'b0}},
                                   lat:   {SLOT_LAT_W{1'b0}}};

endpackage

// File: rtl/hazard_scoreboard_src_match.sv
// Compares one decode source register against every shadow slot.
//   src, used : source address and whether the instruction reads it
//   slots     : shadow pipeline, index 0 = youngest (EX)
//   hazard    : some matching slot has not yet reached its forwardable stage
//   sel       : forwarding select for the youngest matching slot
module src_match
  import hazard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 6,
  parameter int SEL_W  = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] src,
  input  logic              used,
  input  slot_t             slots [DEPTH],
  output logic              hazard,
  output logic [SEL_W-1:0]  sel
);

  // Oldest-to-youngest scan so the youngest match overwrites the select.
  always_comb begin
    hazard = 1'b0;
    sel    = SEL_W'(FWD_REGFILE);
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (used && (src != {ADDR_W{1'b0}}) && slots[k].valid &&
          (slots[k].rd == SLOT_RD_W'(src))) begin
        // Result appears at slot lat; the consumer reaches slot k+1 next.
        if ((k + 1) < int'(slots[k].lat)) begin
          hazard = 1'b1;
        end else begin
          hazard = hazard;
        end
        // The oldest slot retires into the register file this cycle.
        if ((k + 1) < DEPTH) begin
          sel = SEL_W'(k + 1);
        end else begin
          sel = SEL_W'(FWD_REGFILE);
        end
      end else begin
        hazard = hazard;
        sel    = sel;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding controller beside Decode.
//   clk, reset (async, active-low), freeze (global hold), flush (kill decode)
//   dec_*       : decode-stage instruction fields
//   stall       : combinational; hold IF/ID and bubble EX
//   ex_fwd*_sel : registered forwarding selects for the instruction in EX
//   stall_count : saturating count of non-frozen stall cycles
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 6,
  parameter int SEL_W  = $clog2(DEPTH),
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze,
  input  logic              flush,
  input  logic              dec_valid,
  input  logic [ADDR_W-1:0] dec_rs1,
  input  logic [ADDR_W-1:0] dec_rs2,
  input  logic              dec_rs1_used,
  input  logic              dec_rs2_used,
  input  logic [ADDR_W-1:0] dec_rd,
  input  logic              dec_we,
  input  logic [SEL_W-1:0]  dec_lat,
  output logic              stall,
  output logic [SEL_W-1:0]  ex_fwd1_sel,
  output logic [SEL_W-1:0]  ex_fwd2_sel,
  output logic [CNT_W-1:0]  stall_count
);

  slot_t              slot_r [DEPTH];
  slot_t              slot0_s;
  logic               hazard1_s;
  logic               hazard2_s;
  logic [SEL_W-1:0]   sel1_s;
  logic [SEL_W-1:0]   sel2_s;
  logic [SEL_W-1:0]   lat_clamped_s;
  logic               issue_s;
  logic [SEL_W-1:0]   fwd1_r;
  logic [SEL_W-1:0]   fwd2_r;
  logic [CNT_W-1:0]   count_r;

  src_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) u_match1 (
    .src    (dec_rs1),
    .used   (dec_rs1_used),
    .slots  (slot_r),
    .hazard (hazard1_s),
    .sel    (sel1_s)
  );

  src_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) u_match2 (
    .src    (dec_rs2),
    .used   (dec_rs2_used),
    .slots  (slot_r),
    .hazard (hazard2_s),
    .sel    (sel2_s)
  );

  // Out-of-range latencies (0 or past the last slot) mean "as late as possible".
  always_comb begin
    if ((dec_lat == {SEL_W{1'b0}}) || (int'(dec_lat) >= DEPTH)) begin
      lat_clamped_s = SEL_W'(DEPTH - 1);
    end else begin
      lat_clamped_s = dec_lat;
    end
  end

  assign stall   = dec_valid & ~flush & (hazard1_s | hazard2_s);
  assign issue_s = dec_valid & ~flush & ~stall;

  // Entry that enters the EX slot; r0 writes and bubbles are not tracked.
  always_comb begin
    slot0_s.valid = issue_s & dec_we & (dec_rd != {ADDR_W{1'b0}});
    slot0_s.rd    = SLOT_RD_W'(dec_rd);
    slot0_s.lat   = SLOT_LAT_W'(lat_clamped_s);
  end

  // Shadow pipeline shift register, advancing whenever the core is not frozen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_r[k] <= SLOT_EMPTY;
      end
    end else if (!freeze) begin
      slot_r[0] <= slot0_s;
      for (int k = 1; k < DEPTH; k++) begin
        slot_r[k] <= slot_r[k-1];
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_r[k] <= slot_r[k];
      end
    end
  end

  // Forwarding selects follow the instruction into EX; stall/flush sends a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd1_r <= SEL_W'(FWD_REGFILE);
      fwd2_r <= SEL_W'(FWD_REGFILE);
    end else if (!freeze) begin
      if (stall || flush) begin
        fwd1_r <= SEL_W'(FWD_REGFILE);
        fwd2_r <= SEL_W'(FWD_REGFILE);
      end else begin
        fwd1_r <= sel1_s;
        fwd2_r <= sel2_s;
      end
    end else begin
      fwd1_r <= fwd1_r;
      fwd2_r <= fwd2_r;
    end
  end

  // Saturating stall-cycle counter; frozen cycles are not counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (!freeze && stall && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign ex_fwd1_sel = fwd1_r;
  assign ex_fwd2_sel = fwd2_r;
  assign stall_count = count_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: a DEPTH=3 (4-bit counter) and a DEPTH=6 instance share
// stimulus; each is compared against a model of in-flight writes that are
// tracked by issue timestamp.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       freeze, flush, dec_valid;
  logic [5:0] dec_rs1, dec_rs2, dec_rd;
  logic       dec_rs1_used, dec_rs2_used, dec_we;
  logic [2:0] dec_lat6;
  logic [1:0] dec_lat3;
  logic       stall3, stall6;
  logic [1:0] f1_3, f2_3;
  logic [2:0] f1_6, f2_6;
  logic [3:0] cnt3;
  logic [31:0] cnt6;

  assign dec_lat3 = dec_lat6[1:0];

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(3), .ADDR_W(6), .CNT_W(4)) u_d3 (
    .clk(clk), .reset(reset), .freeze(freeze), .flush(flush),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_we(dec_we), .dec_lat(dec_lat3),
    .stall(stall3), .ex_fwd1_sel(f1_3), .ex_fwd2_sel(f2_3), .stall_count(cnt3));

  hazard_scoreboard #(.DEPTH(6), .ADDR_W(6), .CNT_W(32)) u_d6 (
    .clk(clk), .reset(reset), .freeze(freeze), .flush(flush),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_we(dec_we), .dec_lat(dec_lat6),
    .stall(stall6), .ex_fwd1_sel(f1_6), .ex_fwd2_sel(f2_6), .stall_count(cnt6));

  int n_checks = 0;
  int n_errors = 0;

  // Model: per instance, a set of writes stamped with the advance count at issue.
  int     dep [2]     = '{3, 6};
  longint cnt_max [2] = '{64'd15, 64'd4294967295};
  int     adv [2];
  bit     m_use [2][8];
  int     m_rd  [2][8];
  int     m_lat [2][8];
  int     m_t   [2][8];
  int     exp_s1 [2], exp_s2 [2];
  longint exp_cnt [2];
  bit     exp_st [2];
  bit     obs_st6;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) begin
      adv[i] = 0; exp_s1[i] = 0; exp_s2[i] = 0; exp_cnt[i] = 0;
      for (int e = 0; e < 8; e++) m_use[i][e] = 1'b0;
    end
  endfunction

  // Hazard and youngest-producer select for one source, from write ages.
  function automatic void lookup(input int i, input int s, input bit used,
                                 output bit haz, output int sel);
    int best = 1000;
    haz = 1'b0;
    for (int e = 0; e < 8; e++) begin
      int age = adv[i] - m_t[i][e] - 1;
      if (m_use[i][e] && used && s != 0 && m_rd[i][e] == s && age < dep[i]) begin
        if (age + 1 < m_lat[i][e]) haz = 1'b1;
        if (age < best) best = age;
      end
    end
    sel = (best == 1000) ? 0 : ((best + 1 < dep[i]) ? best + 1 : 0);
  endfunction

  function automatic int clamp_lat(input int i, input int l);
    return (l == 0 || l >= dep[i]) ? dep[i] - 1 : l;
  endfunction

  // One clock: check stall before the edge, registered outputs after it.
  task automatic cycle();
    bit h1, h2;
    int s1 [2], s2 [2];
    #1;
    for (int i = 0; i < 2; i++) begin
      lookup(i, dec_rs1, dec_rs1_used, h1, s1[i]);
      lookup(i, dec_rs2, dec_rs2_used, h2, s2[i]);
      exp_st[i] = dec_valid && !flush && (h1 || h2);
    end
    chk("stall_d3", stall3, exp_st[0]);
    chk("stall_d6", stall6, exp_st[1]);
    obs_st6 = stall6;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!freeze) begin
        int l = (i == 0) ? int'(dec_lat6 & 3'd3) : int'(dec_lat6);
        if (exp_st[i] && exp_cnt[i] < cnt_max[i]) exp_cnt[i]++;
        exp_s1[i] = (exp_st[i] || flush) ? 0 : s1[i];
        exp_s2[i] = (exp_st[i] || flush) ? 0 : s2[i];
        if (dec_valid && !flush && !exp_st[i] && dec_we && dec_rd != 0) begin
          for (int e = 0; e < 8; e++) begin
            if (!m_use[i][e]) begin
              m_use[i][e] = 1'b1; m_rd[i][e] = dec_rd;
              m_lat[i][e] = clamp_lat(i, l); m_t[i][e] = adv[i];
              break;
            end
          end
        end
        adv[i]++;
        for (int e = 0; e < 8; e++)
          if (m_use[i][e] && adv[i] - m_t[i][e] - 1 >= dep[i]) m_use[i][e] = 1'b0;
      end
    end
    chk("fwd1_d3", f1_3, exp_s1[0]);
    chk("fwd2_d3", f2_3, exp_s2[0]);
    chk("cnt_d3", cnt3, exp_cnt[0]);
    chk("fwd1_d6", f1_6, exp_s1[1]);
    chk("fwd2_d6", f2_6, exp_s2[1]);
    chk("cnt_d6", cnt6, exp_cnt[1]);
  endtask

  task automatic drive(input bit v, input bit fl, input bit fz,
                       input int r1, input bit u1, input int r2, input bit u2,
                       input int rd, input bit we, input int lat);
    dec_valid = v; flush = fl; freeze = fz;
    dec_rs1 = 6'(r1); dec_rs1_used = u1; dec_rs2 = 6'(r2); dec_rs2_used = u2;
    dec_rd = 6'(rd); dec_we = we; dec_lat6 = 3'(lat);
    cycle();
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1);
  endtask

  // Hold a consumer of rs1 in decode until the DEPTH=6 copy stops stalling.
  task automatic consume(input int r1, output int stalls6);
    stalls6 = 0;
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, 1'b0, 1'b0, r1, 1'b1, 0, 1'b0, 20, 1'b1, 1);
      if (!obs_st6) break;
      stalls6++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_stall_d3", stall3, 0);
    chk("rst_stall_d6", stall6, 0);
    chk("rst_fwd1_d3", f1_3, 0);
    chk("rst_fwd1_d6", f1_6, 0);
    chk("rst_cnt_d3", cnt3, 0);
    chk("rst_cnt_d6", cnt6, 0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int ns;
    dec_valid = 1'b0; flush = 1'b0; freeze = 1'b0; dec_we = 1'b0;
    dec_rs1 = 6'd0; dec_rs2 = 6'd0; dec_rd = 6'd0; dec_lat6 = 3'd1;
    dec_rs1_used = 1'b0; dec_rs2_used = 1'b0;
    do_reset();
    idle(1);

    // ALU chain: no stall, forward from slot 1.
    drive(1'b1, 1'b0, 1'b0, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1);
    drive(1'b1, 1'b0, 1'b0, 3, 1'b1, 5, 1'b1, 4, 1'b1, 1);
    chk("alu_sel", f1_3, 1);
    idle(6);

    // Load-use: one stall, then select 2.
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 3, 1'b1, 2);
    consume(3, ns);
    chk("lu_stalls", ns, 1);
    chk("lu_sel", f1_3, 2);
    chk("lu_cnt", cnt3, 1);
    idle(6);

    // FPU latency 4: three stalls back to back, two with a gap.
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 9, 1'b1, 4);
    consume(9, ns);
    chk("fpu_stalls", ns, 3);
    chk("fpu_sel", f1_6, 4);
    idle(6);
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 9, 1'b1, 4);
    drive(1'b1, 1'b0, 1'b0, 1, 1'b1, 2, 1'b1, 11, 1'b1, 1);
    consume(9, ns);
    chk("fpu_gap_stalls", ns, 2);
    idle(6);

    // r0 never tracked; two writers of r7 -> youngest wins.
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1, 2);
    drive(1'b1, 1'b0, 1'b0, 0, 1'b1, 0, 1'b1, 5, 1'b1, 1);
    chk("r0_sel", f1_3, 0);
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1);
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1);
    drive(1'b1, 1'b0, 1'b0, 7, 1'b1, 0, 1'b0, 8, 1'b1, 1);
    chk("prio_sel", f1_3, 1);
    idle(6);

    // Freeze during a load-use stall, then release.
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 3, 1'b1, 2);
    for (int c = 0; c < 3; c++) drive(1'b1, 1'b0, 1'b1, 3, 1'b1, 0, 1'b0, 4, 1'b1, 1);
    consume(3, ns);
    chk("frz_stalls", ns, 1);
    idle(6);

    // Flush of a hazardous decode.
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 3, 1'b1, 2);
    drive(1'b1, 1'b1, 1'b0, 3, 1'b1, 3, 1'b1, 4, 1'b1, 1);
    chk("flush_sel", f1_3, 0);
    idle(6);

    // Reset with in-flight writes, then a dependent instruction.
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 10, 1'b1, 2);
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 11, 1'b1, 2);
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 12, 1'b1, 5);
    dec_valid = 1'b1; dec_rs1 = 6'd12; dec_rs1_used = 1'b1;
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 12, 1'b1, 11, 1'b1, 13, 1'b1, 1);
    chk("post_rst_sel", f1_6, 0);

    // Random traffic over a small register set to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 1) != 0,
            $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7));
      if (c == 1500) begin
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-detection and forwarding controller for the pipelined DLX core. It replaces the hard-wired `stall = 0` and fixed two-source forwarding in the core with a shadow pipeline of in-flight register writes. Each write carries its own result latency, so the controller covers:
- ALU results,
- load-use hazards,
- multi-cycle FPU results.

It sits beside Decode. It produces the decode stall and the registered forwarding selects consumed by Execute when the instruction arrives there.

## Interface
- `DEPTH`, 3: shadow slots past decode; slot 0=EX, 1=MEM, 2=WB, 3..DEPTH-1 = extra FPU stages.
- `ADDR_W`, 6: register address width (int + FP file).
- `SEL_W`, `$clog2(DEPTH)`: forwarding select width.
- `CNT_W`, 32: stall performance counter width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `freeze` in 1: global hold (memory miss); slots and registered outputs hold.
- `flush` in 1: kills the decode instruction this cycle.
- `dec_valid` in 1: decode holds a real instruction.
- `dec_rs1`, `dec_rs2` in `ADDR_W`: source addresses.
- `dec_rs1_used`, `dec_rs2_used` in 1: source actually read.
- `dec_rd` in `ADDR_W`: destination.
- `dec_we` in 1: instruction writes `dec_rd`.
- `dec_lat` in `SEL_W`: slot index L at which the result becomes forwardable (ALU=1, load=2, FPU up to DEPTH-1).
- `stall` out 1: combinational; hold IF/ID, inject bubble into EX.
- `ex_fwd1_sel`, `ex_fwd2_sel` out `SEL_W`: registered; 0 = register file, m = slot m output.
- `stall_count` out `CNT_W`: saturating count of stall cycles.

## Operation
- **Slot contents:** each slot k holds `valid`, `rd`, `lat`. On advance (`!freeze`), slot k+1 takes slot k, and slot DEPTH-1 retires to the register file.
- **Slot 0 load:** slot 0 takes `{issue, dec_rd, lat_clamped}`.
  - `issue = dec_valid & !flush & !stall`.
  - A write is recorded only if `dec_we` and `dec_rd` != 0.
- **Latency clamp:** `lat_clamped` maps `dec_lat` of 0 or ≥DEPTH to DEPTH-1.
- **Match:** source s matches slot k when:
  - s is used,
  - s != 0,
  - slot k is valid,
  - slot k `rd` == s.
- **Stall:** asserted if any match has k+1 < `lat` of slot k. Evaluated only when `dec_valid & !flush`, so flush forces `stall` = 0.
- **Forwarding select:**
  - Among matching slots, the youngest (lowest k) wins.
  - Next-cycle select = k+1 if k+1 < DEPTH, else 0.
  - No match gives 0.
- **Select register update:**
  - Registered selects load on advance.
  - On stall or flush they load 0 (bubble in EX).
  - On freeze they hold.
- **Register 0:** never tracked or matched.
- **`stall_count`:** increments on each cycle with `stall & !freeze`, saturating at all-ones.

## Timing
- **Reset:** all slots invalid, `ex_fwd*_sel` = 0, `stall_count` = 0. `stall` = 0 because no slot is valid.
- **Stall path:** `stall` is same-cycle combinational from decode inputs and slot state.
- **Select latency:** selects are valid one cycle after decode, aligned with the consumer in EX.
- **Load-use (DEPTH=3, L=2):** 1 stall cycle, then select 2.
- **FPU:** back-to-back dependency with latency L gives L-1 stall cycles.
- **Freeze with stall:** freeze dominates; `stall` may stay high, but the counter and state hold.
- **Reset mid-stall:** all in-flight writes are dropped immediately (async). The first cycle after release sees no hazards.

## Structure
- Package `hazard_pkg`:
  - slot struct `{valid, rd, lat}`,
  - `FWD_REGFILE` = 0,
  - ALU/LOAD latency constants (1, 2).
- Sub-module `src_match` (instantiated twice): one source against all slots, returning `hazard` and `sel` via a youngest-first priority encoder.
- Top: slot shift register, issue logic, select registers, counter.

## Test plan
- **ALU chain:** `ADD r3←r1,r2` then `SUB r4←r3,r5` (L=1) → `stall` = 0, `ex_fwd1_sel` = 1 next cycle.
- **Load-use (DEPTH=3):** `LW r3` then `ADD r4←r3` → `stall` high exactly 1 cycle, then `ex_fwd1_sel` = 2, `stall_count` = 1.
- **FPU (DEPTH=6, L=4):** dependent `MULTF` then consumer → 3 stall cycles, then select 4. A one-instruction gap gives 2 stall cycles.
- **Register 0 and priority:**
  - Writes to r0 → no stall, select 0.
  - Two in-flight writers to r7 (slots 0 and 1) → select 1 (youngest).
- **Freeze / flush:**
  - `freeze` during a load-use stall for 3 cycles → state, selects and counter hold; stall resolves 1 advance after release.
  - `flush` with a hazardous decode → `stall` = 0, EX select 0.
- **Reset mid-operation:** assert `reset` low with 3 valid slots → outputs 0 asynchronously. After release, a dependent instruction gives no stall and select 0.
